// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with a one-entry holding register.
// Frames are start(0), data LSB first, P_STOP_BITS stop bits(1).
`default_nettype none

module uart_tx #(
  parameter int P_UART_WIDTH = 8,
  parameter int P_BAUD       = 9600,
  parameter int P_SYS_CLK_HZ = 5000000,
  parameter int P_STOP_BITS  = 1
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic [P_UART_WIDTH-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    serial_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int LP_BIT_CYCLES = P_SYS_CLK_HZ / P_BAUD;
  localparam int LP_CNT_W      = (LP_BIT_CYCLES > 1) ? $clog2(LP_BIT_CYCLES) : 1;
  localparam int LP_BIT_W      = $clog2(P_UART_WIDTH + 1);

  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST  = LP_CNT_W'(LP_BIT_CYCLES - 1);
  localparam logic [LP_BIT_W-1:0] LP_DATA_LAST = LP_BIT_W'(P_UART_WIDTH - 1);
  localparam logic [LP_BIT_W-1:0] LP_STOP_LAST = LP_BIT_W'(P_STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]              r_state;
  logic [LP_CNT_W-1:0]     r_baud_cnt;
  logic [LP_BIT_W-1:0]     r_bit_cnt;
  logic [P_UART_WIDTH-1:0] r_shift;
  logic [P_UART_WIDTH-1:0] r_hold;
  logic                    r_hold_full;
  logic                    r_line;

  logic                    w_bit_end;
  logic                    w_last_stop;
  logic                    w_load;
  logic                    w_accept;
  logic [P_UART_WIDTH-1:0] w_shift_next;

  assign w_bit_end    = (r_baud_cnt == LP_CNT_LAST);
  assign w_last_stop  = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == LP_STOP_LAST);
  // Reload from IDLE, or straight out of the final stop bit for gapless frames.
  assign w_load       = r_hold_full && ((r_state == S_IDLE) || w_last_stop);
  assign w_accept     = data_valid && !r_hold_full;
  assign w_shift_next = r_shift >> 1;

  assign data_ready = !r_hold_full;
  assign serial_out = r_line;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_last_stop;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold      <= data_in;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Held at zero while idle so the first start bit is a full bit period.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_baud_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit_end) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_line    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_shift   <= r_hold;
            r_bit_cnt <= '0;
            r_line    <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_line    <= r_shift[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LP_DATA_LAST) begin
              r_bit_cnt <= '0;
              r_line    <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_line    <= w_shift_next[0];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LP_STOP_LAST) begin
              r_bit_cnt <= '0;
              if (r_hold_full) begin
                r_shift <= r_hold;
                r_line  <= 1'b0;
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_line    <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter; the stage directly upstream of the UART receiver. It drives the line the receiver samples as serial_in.
It accepts parallel bytes through a valid/ready handshake into a one-entry holding register. It then shifts each byte out as an 8N1 frame: start bit 0, data LSB first, stop bit 1.
The holding register allows back-to-back frames with no idle gap, so the receiver FIFO path can be stress-tested at full line rate.

Parameters:
P_UART_WIDTH, 8, data bits per frame (1..14)
P_BAUD, 9600, line rate in bit/s
P_SYS_CLK_HZ, 5000000, CLK frequency; bit period LP_BIT_CYCLES = P_SYS_CLK_HZ / P_BAUD (integer division, must be >= 2)
P_STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
CLK  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  P_UART_WIDTH  byte to send
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  holding register empty; transfer occurs when data_valid & data_ready at a rising edge
serial_out  output  1  UART line; idles high
busy  output  1  a frame is on the line (any state except S_IDLE)
frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset (reset_n low, asynchronous assert; deassert takes effect at the next edge): serial_out=1, data_ready=1, busy=0, frame_done=0. Holding register is emptied, FSM goes to S_IDLE, bit counter=0, baud counter=0. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Holding register:
  - Loads data_in on data_valid & data_ready.
  - data_ready is registered: it is 0 from the cycle after acceptance until the FSM copies the holding register into the shift register. It returns to 1 the cycle after that copy.
  - data_in is ignored while data_ready=0.
- FSM states: S_IDLE, S_START, S_DATA, S_STOP.
  - S_IDLE: serial_out=1. If the holding register is full, copy it to the shifter, mark it empty, clear the baud counter and go to S_START.
  - S_START: serial_out=0 for LP_BIT_CYCLES cycles, then go to S_DATA with bit counter=0.
  - S_DATA: serial_out=shifter[0]. Each bit is held LP_BIT_CYCLES cycles; then shift right and increment the bit counter. After bit P_UART_WIDTH-1 completes, go to S_STOP.
  - S_STOP: serial_out=1 for P_STOP_BITS*LP_BIT_CYCLES cycles. On the final cycle, pulse frame_done. If the holding register is full, load it and go directly to S_START (no idle cycle); otherwise go to S_IDLE.
- Baud counter:
  - Width ceil(log2(LP_BIT_CYCLES)); counts 0..LP_BIT_CYCLES-1.
  - The bit-end strobe is count==LP_BIT_CYCLES-1, after which the counter wraps to 0.
  - The counter is held at 0 in S_IDLE so the first start bit is exactly LP_BIT_CYCLES long.
- Latency:
  - data_valid sampled high at edge k while idle and empty: the holding register is full after edge k.
  - serial_out falls after edge k+1.
  - A frame lasts (1+P_UART_WIDTH+P_STOP_BITS)*LP_BIT_CYCLES cycles.
- Simultaneous events: a new byte may be accepted in the same cycle the FSM empties the holding register only if data_ready was already 1. There is no combinational ready path, so at most one byte is held plus one in flight.
- serial_out is registered (glitch-free) and changes only on bit boundaries.

Test Plan:
- Reset/idle: assert reset_n=0 mid-frame -> serial_out=1, data_ready=1, busy=0 immediately (asynchronous); after release the line stays high with no data_valid.
- Single byte, P_SYS_CLK_HZ=160, P_BAUD=10 (LP_BIT_CYCLES=16), send 8'hA5:
  - serial_out falls 2 cycles after data_valid.
  - Sampled every 16 cycles: 0,1,0,1,0,0,1,0,1,1.
  - frame_done pulses once at cycle 160 of the frame; busy drops the next cycle.
- Back-to-back: send 8'h00 then 8'hFF while the first frame is active -> the second accept waits for data_ready. The stop bit of frame 1 is followed directly by the start bit of frame 2 with 0 idle cycles. A third byte offered during frame 1 is held off (data_ready=0).
- Loopback: connect serial_out to the receiver's serial_in at P_BAUD=9600 and send 8'h3C, 8'hC3, 8'h81 -> the receiver FIFO returns the same three bytes in order with error=0.
- Two stop bits (P_STOP_BITS=2), send 8'h55 -> the high stop interval is 32 cycles; frame length is 176 cycles.
- Valid without ready: hold data_valid=1 with changing data_in during a frame -> only the value present in the cycle data_ready=1 is transmitted.
